// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the irq_ctrl interrupt controller: register map,
// VECTOR layout, default sizing and the priority-encoder helper.
package irq_ctrl_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_ENABLE = 2'd1;
  localparam logic [1:0] REG_EDGE   = 2'd2;
  localparam logic [1:0] REG_VECTOR = 2'd3;

  localparam int VEC_NONE_BIT    = 7;
  localparam int NSRC_DEF        = 8;
  localparam int SYNC_STAGES_DEF = 2;

  // Lowest-numbered pending bit wins; with nothing pending only the none
  // bit is set and the index field stays 0.
  function automatic logic [7:0] vector_of(input logic [7:0] pend);
    logic [7:0] v;
    v = 8'h00;
    v[VEC_NONE_BIT] = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (pend[i]) begin
        v = {1'b0, 4'b0000, i[2:0]};
      end else begin
        v = v;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU-side register bus of the interrupt controller (page 3x decode).
interface irq_ctrl_if;
  logic       cs;
  logic       we;
  logic [1:0] rs;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output cs, output we, output rs, output din, input dout);
  modport slave  (input cs, input we, input rs, input din, output dout);
endinterface

// File: rtl/irq_sync_edge.sv
// One interrupt source: synchroniser, previous-sample flop and edge latch.
// The level path reports the previous sample so that level and edge sources
// reach ACTIVE at the same posedge after the input rises.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic edge_mode,
  input  logic mode_clr,
  input  logic set_sw,
  input  logic clr_w1c,
  output logic active
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   latch_r;
  logic                   rise_s;

  assign rise_s = sync_r[SYNC_STAGES-1] & ~prev_r;

  // Synchronise the asynchronous request and keep last cycle's sample.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], src};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Edge latch: switching to level mode clears it, set beats W1C clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      latch_r <= 1'b0;
    end else if (mode_clr) begin
      latch_r <= 1'b0;
    end else if (edge_mode) begin
      latch_r <= (latch_r & ~clr_w1c) | rise_s | set_sw;
    end else begin
      latch_r <= 1'b0;
    end
  end

  assign active = edge_mode ? latch_r : prev_r;

endmodule

// File: rtl/irq_ctrl.sv
// Priority interrupt controller: register file, per-source sync/latch,
// priority-encoded VECTOR, registered read data and registered IRQ.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC        = NSRC_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  irq_ctrl_if.slave       bus,
  input  logic [NSRC-1:0] irq_src,
  output logic            irq
);

  logic [NSRC-1:0] enable_r;
  logic [NSRC-1:0] edge_r;
  logic [NSRC-1:0] active_s;
  logic [NSRC-1:0] din_s;
  logic            wr_s;
  logic            wr_status_s;
  logic            wr_enable_s;
  logic            wr_edge_s;
  logic            wr_vector_s;
  logic [7:0]      pend8_s;
  logic [7:0]      enable8_s;
  logic [7:0]      edge8_s;
  logic [7:0]      rdata_s;
  logic [7:0]      dout_r;
  logic            irq_r;

  assign din_s       = bus.din[NSRC-1:0];
  assign wr_s        = bus.cs & bus.we;
  assign wr_status_s = wr_s & (bus.rs == REG_STATUS);
  assign wr_enable_s = wr_s & (bus.rs == REG_ENABLE);
  assign wr_edge_s   = wr_s & (bus.rs == REG_EDGE);
  assign wr_vector_s = wr_s & (bus.rs == REG_VECTOR);

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_src (
      .clk       (clk),
      .reset     (reset),
      .src       (irq_src[g]),
      .edge_mode (edge_r[g]),
      .mode_clr  (wr_edge_s & ~din_s[g]),
      .set_sw    (wr_vector_s & din_s[g]),
      .clr_w1c   (wr_status_s & din_s[g]),
      .active    (active_s[g])
    );
  end

  // ENABLE and EDGE registers; reset wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      enable_r <= {NSRC{1'b0}};
      edge_r   <= {NSRC{1'b0}};
    end else begin
      if (wr_enable_s) begin
        enable_r <= din_s;
      end
      if (wr_edge_s) begin
        edge_r <= din_s;
      end
    end
  end

  // Widen per-source state to 8 bits; unimplemented bits read as 0.
  always_comb begin
    pend8_s   = 8'h00;
    enable8_s = 8'h00;
    edge8_s   = 8'h00;
    for (int i = 0; i < NSRC; i++) begin
      pend8_s[i]   = active_s[i] & enable_r[i];
      enable8_s[i] = enable_r[i];
      edge8_s[i]   = edge_r[i];
    end
  end

  // Read mux selected by rs, independent of cs.
  always_comb begin
    rdata_s = 8'h00;
    case (bus.rs)
      REG_STATUS: rdata_s = pend8_s;
      REG_ENABLE: rdata_s = enable8_s;
      REG_EDGE:   rdata_s = edge8_s;
      REG_VECTOR: rdata_s = vector_of(pend8_s);
      default:    rdata_s = 8'h00;
    endcase
  end

  // Registered read data and IRQ line.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dout_r <= 8'h00;
      irq_r  <= 1'b0;
    end else begin
      dout_r <= rdata_s;
      irq_r  <= |pend8_s;
    end
  end

  assign bus.dout = dout_r;
  assign irq      = irq_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a table of register accesses followed by
// hand-written multi-cycle sequences for latency and corner cases.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  typedef struct {
    logic       is_wr;
    logic [1:0] rs;
    logic [7:0] data;
    logic [7:0] exp;
    logic       exp_irq;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [7:0] irq_src;
  logic       irq;
  int         checks;
  int         errors;
  vec_t       tbl[$];
  logic [7:0] rdv;

  irq_ctrl_if bus();

  irq_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .irq_src (irq_src),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.cs = 1'b1; bus.we = 1'b1; bus.rs = a; bus.din = d;
    tick();
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    bus.cs = 1'b1; bus.we = 1'b0; bus.rs = a;
    tick();
    d = bus.dout;
    bus.cs = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic tw(input logic [1:0] a, input logic [7:0] d);
    tbl.push_back('{1'b1, a, d, 8'h00, 1'b0});
  endtask

  task automatic tr(input logic [1:0] a, input logic [7:0] e, input logic ei);
    tbl.push_back('{1'b0, a, 8'h00, e, ei});
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; irq_src = 8'h00;
    bus.cs = 1'b0; bus.we = 1'b0; bus.rs = 2'd0; bus.din = 8'h00;

    tr(REG_STATUS, 8'h00, 1'b0); tr(REG_ENABLE, 8'h00, 1'b0);
    tr(REG_EDGE,   8'h00, 1'b0); tr(REG_VECTOR, 8'h80, 1'b0);
    tw(REG_ENABLE, 8'h5A); tr(REG_ENABLE, 8'h5A, 1'b0);
    tw(REG_EDGE,   8'h3C); tr(REG_EDGE,   8'h3C, 1'b0);
    tw(REG_VECTOR, 8'h24); tr(REG_STATUS, 8'h00, 1'b0);
    tw(REG_ENABLE, 8'hFF); tr(REG_STATUS, 8'h24, 1'b1);
    tr(REG_VECTOR, 8'h02, 1'b1);
    tw(REG_STATUS, 8'h04); tr(REG_VECTOR, 8'h05, 1'b1);
    tw(REG_STATUS, 8'h20); tr(REG_VECTOR, 8'h80, 1'b0);
    tw(REG_VECTOR, 8'h03); tr(REG_STATUS, 8'h00, 1'b0);
    tw(REG_VECTOR, 8'h08); tr(REG_STATUS, 8'h08, 1'b1);
    tw(REG_EDGE,   8'h34); tr(REG_STATUS, 8'h00, 1'b0);
    tr(REG_EDGE,   8'h34, 1'b0);

    tick(); tick();
    check("reset_irq", {7'd0, irq}, 8'h00);
    check("reset_dout", bus.dout, 8'h00);
    reset = 1'b1;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].is_wr) begin
        wr(tbl[i].rs, tbl[i].data);
      end else begin
        rd(tbl[i].rs, rdv);
        check($sformatf("tbl%0d_data", i), rdv, tbl[i].exp);
        check($sformatf("tbl%0d_irq", i), {7'd0, irq}, {7'd0, tbl[i].exp_irq});
      end
    end

    // All sources high while disabled.
    do_reset();
    irq_src = 8'hFF;
    for (int t = 0; t < 20; t++) begin
      tick();
      check("masked_irq", {7'd0, irq}, 8'h00);
    end
    rd(REG_STATUS, rdv); check("masked_status", rdv, 8'h00);
    irq_src = 8'h00;
    repeat (4) tick();

    // Level source latency and VECTOR while asserted.
    wr(REG_ENABLE, 8'h04);
    bus.rs = REG_VECTOR;
    for (int t = 1; t <= 16; t++) begin
      irq_src = (t <= 10) ? 8'h04 : 8'h00;
      tick();
      check($sformatf("level_irq_t%0d", t), {7'd0, irq}, ((t >= 4) && (t <= 13)) ? 8'h01 : 8'h00);
      check($sformatf("level_vec_t%0d", t), bus.dout, ((t >= 4) && (t <= 13)) ? 8'h02 : 8'h80);
    end

    // Edge source: single-cycle pulse, W1C, W1C racing a rise.
    wr(REG_EDGE, 8'h01); wr(REG_ENABLE, 8'h01);
    irq_src = 8'h01; tick(); irq_src = 8'h00;
    repeat (4) tick();
    check("edge_irq", {7'd0, irq}, 8'h01);
    rd(REG_STATUS, rdv); check("edge_status", rdv, 8'h01);
    wr(REG_STATUS, 8'h01);
    check("w1c_irq_same", {7'd0, irq}, 8'h01);
    tick();
    check("w1c_irq_next", {7'd0, irq}, 8'h00);
    irq_src = 8'h01; tick(); tick();
    wr(REG_STATUS, 8'h01);
    irq_src = 8'h00;
    rd(REG_STATUS, rdv); check("rise_beats_w1c", rdv, 8'h01);
    wr(REG_STATUS, 8'h01);
    rd(REG_STATUS, rdv); check("w1c_clears", rdv, 8'h00);

    // Priority encoding.
    wr(REG_EDGE, 8'hFF); wr(REG_ENABLE, 8'hFF);
    wr(REG_VECTOR, 8'h90);
    rd(REG_VECTOR, rdv); check("prio_4", rdv, 8'h04);
    wr(REG_STATUS, 8'h10);
    rd(REG_VECTOR, rdv); check("prio_7", rdv, 8'h07);
    wr(REG_STATUS, 8'h80);
    rd(REG_VECTOR, rdv); check("prio_none", rdv, 8'h80);
    check("prio_irq", {7'd0, irq}, 8'h00);

    // Switching to edge mode while the source is already high.
    wr(REG_EDGE, 8'h00);
    irq_src = 8'h08; repeat (5) tick();
    wr(REG_EDGE, 8'h08); repeat (3) tick();
    rd(REG_STATUS, rdv); check("mode_no_latch", rdv, 8'h00);
    irq_src = 8'h00; repeat (3) tick();
    irq_src = 8'h08; repeat (4) tick();
    rd(REG_STATUS, rdv); check("mode_new_rise", rdv, 8'h08);
    check("mode_irq", {7'd0, irq}, 8'h01);

    // Reset during activity with a write in flight.
    reset = 1'b0;
    bus.cs = 1'b1; bus.we = 1'b1; bus.rs = REG_ENABLE; bus.din = 8'h55;
    tick();
    check("midreset_irq", {7'd0, irq}, 8'h00);
    check("midreset_dout", bus.dout, 8'h00);
    reset = 1'b1; bus.cs = 1'b0; bus.we = 1'b0; irq_src = 8'h00;
    rd(REG_ENABLE, rdv); check("midreset_enable", rdv, 8'h00);
    rd(REG_EDGE, rdv);   check("midreset_edge", rdv, 8'h00);
    rd(REG_VECTOR, rdv); check("midreset_vector", rdv, 8'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
